// File: rtl/add_seq16_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_e : FSM state encoding
//   OP_*    : operation encoding for op_i
//   IDX_W   : width of the nibble index counter (covers NIB up to 8)
package add_seq16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int IDX_W = 3;

endpackage

// File: rtl/add_seq16_add4_slice.sv
// Combinational 4-bit carry-lookahead slice.
//   a, b : nibble operands
//   m    : 1 inverts b (subtract)
//   cin  : carry into bit 0
//   s    : nibble sum
//   c4   : carry out of bit 3
//   c3   : carry into bit 3, used for signed overflow at the MSB nibble
module add4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       m,
   input  logic       cin,
   output logic [3:0] s,
   output logic       c4,
   output logic       c3
);

   logic [3:0] bx;
   logic [3:0] p;
   logic [3:0] g;
   logic       c1;
   logic       c2;

   assign bx = b ^ {4{m}};
   assign p  = a ^ bx;
   assign g  = a & bx;

   assign c1 = g[0] | (p[0] & cin);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/add_seq16.sv
// Nibble-serial W-bit add/subtract through one shared 4-bit CLA slice,
// LSB nibble first, carry chained through a register.
//   clk, rst_n         : clock, synchronous active-low reset
//   start_i            : request, accepted in IDLE or DONE
//   op_i, cin_i        : 0 = A+B+cin, 1 = A-B-borrow
//   a_i, b_i           : operands, captured on an accepted start
//   flush_i            : synchronous abort of RUN/DONE
//   busy_o             : high while in RUN
//   done_o             : one-cycle pulse when results are valid
//   s_o, cf_o, of_o, zf_o : result and flags, updated on entry to DONE
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one nibble per cycle through the slice, idx 0..NIB-1
// DONE  | result visible, done_o pulses, back-to-back start allowed
module add_seq16
   import add_seq16_pkg::*;
#(
   parameter  int NIB = 4,
   localparam int W   = 4 * NIB
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic         op_i,
   input  logic         cin_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         flush_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] s_o,
   output logic         cf_o,
   output logic         of_o,
   output logic         zf_o
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_sh_q, a_sh_d;
   logic [W-1:0]       b_sh_q, b_sh_d;
   logic               m_q, m_d;
   logic               c_q, c_d;
   logic [W-1:0]       stg_q, stg_d;
   logic [W-1:0]       s_q, s_d;
   logic               cf_q, cf_d;
   logic               of_q, of_d;
   logic               zf_q, zf_d;
   logic               busy_q, busy_d;

   logic               load;
   logic [3:0]         sl_s;
   logic               sl_c4;
   logic               sl_c3;

   // Operands are shifted right each RUN cycle so the slice always sees bits [3:0].
   add4_slice u_slice (
      .a   (a_sh_q[3:0]),
      .b   (b_sh_q[3:0]),
      .m   (m_q),
      .cin (c_q),
      .s   (sl_s),
      .c4  (sl_c4),
      .c3  (sl_c3)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      m_d     = m_q;
      c_d     = c_q;
      stg_d   = stg_q;
      s_d     = s_q;
      cf_d    = cf_q;
      of_d    = of_q;
      zf_d    = zf_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) load = 1'b1;
         end
         RUN: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               a_sh_d = a_sh_q >> 4;
               b_sh_d = b_sh_q >> 4;
               c_d    = sl_c4;
               stg_d[{idx_q, 2'b00} +: 4] = sl_s;
               if (idx_q == IDX_W'(NIB - 1)) begin
                  // Publish the whole result at once; partial nibbles stay in stg.
                  s_d     = stg_d;
                  zf_d    = (stg_d == '0);
                  cf_d    = sl_c4;
                  of_d    = sl_c3 ^ sl_c4;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (flush_i)      state_d = IDLE;
            else if (start_i) load    = 1'b1;
            else              state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         a_sh_d  = a_i;
         b_sh_d  = b_i;
         m_d     = (op_i == OP_SUB);
         // Subtract is A + ~B + 1 - borrow, so the initial carry is cin inverted.
         c_d     = cin_i ^ (op_i != OP_ADD);
         idx_d   = '0;
         state_d = RUN;
      end

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         m_q     <= 1'b0;
         c_q     <= 1'b0;
         stg_q   <= '0;
         s_q     <= '0;
         cf_q    <= 1'b0;
         of_q    <= 1'b0;
         zf_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         m_q     <= m_d;
         c_q     <= c_d;
         stg_q   <= stg_d;
         s_q     <= s_d;
         cf_q    <= cf_d;
         of_q    <= of_d;
         zf_q    <= zf_d;
         busy_q  <= busy_d;
      end
   end

   // A flush arriving in DONE suppresses the pulse in that same cycle.
   assign done_o = (state_q == DONE) && !flush_i;
   assign busy_o = busy_q;
   assign s_o    = s_q;
   assign cf_o   = cf_q;
   assign of_o   = of_q;
   assign zf_o   = zf_q;

endmodule

// File: doc/add_seq16.md
Name: add_seq16

Overview:
- Multi-cycle sequencer that runs a W-bit add/subtract through one shared 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles in a register.
- Used where area matters more than latency: the pipeline's ALU stage issues a request, waits for done, then reads the result and flags.

Parameters:
- NIB, 4, number of 4-bit nibbles per operand (legal 2..8).
- W, 4*NIB, operand/result width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- start_i  input  1  request; sampled only in IDLE or DONE.
- op_i  input  1  0 = A + B + cin, 1 = A - B - borrow.
- cin_i  input  1  carry-in (add) or borrow-in (sub).
- a_i  input  W  operand A, captured on accepted start.
- b_i  input  W  operand B, captured on accepted start.
- flush_i  input  1  synchronous abort.
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle pulse, results valid.
- s_o  output  W  result.
- cf_o  output  1  carry-out of bit W-1 (sub: 1 = no borrow).
- of_o  output  1  signed overflow.
- zf_o  output  1  s_o == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: state = IDLE. busy_o, done_o, s_o, cf_o, of_o, zf_o, the nibble index and the carry register are all 0. A reset asserted mid-RUN takes priority over every other input and discards the operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start_i=1 → capture a_i, b_i and op_i. Load carry register with cin_i XOR op_i (sub with no borrow feeds 1). Set idx=0. Go to RUN.
  - RUN: each cycle the slice computes nibble idx of A + (B XOR {W{op}}) + carry. Write the slice sum into s-register bits [4*idx+3:4*idx] and latch the slice carry-out into the carry register. At idx=NIB-1, also latch cf and of, then go to DONE. Otherwise idx increments.
  - DONE: done_o=1 for exactly this cycle. cf_o, of_o and zf_o are updated from the completed result. start_i=1 here is accepted (back-to-back, same capture as IDLE) → RUN. Otherwise → IDLE.
- Latency: start sampled in cycle T → done_o high in cycle T+NIB+1. Throughput: one operation per NIB+1 cycles.
- Output updates:
  - s_o is a staging register. The visible s_o and flags update only on entry to DONE and then hold until the next DONE.
  - Partial nibbles are never visible on s_o.
- Flag definitions:
  - of = carry-in of bit W-1 XOR carry-out of bit W-1; the slice exports its MSB-internal carry for this.
  - zf from the full W-bit staged result.
- Ignored inputs:
  - start_i in RUN is ignored; no queuing.
  - Operand inputs are ignored except on an accepted start.
- flush_i:
  - In RUN or DONE: next state IDLE, done_o not asserted (suppressed if in DONE this cycle).
  - Visible outputs keep their previous values.
  - flush_i has priority over start_i.
- busy_o = (state == RUN), registered.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), op encoding (OP_ADD=0, OP_SUB=1), NIB width constant for the index counter.
- One sub-module, add4_slice: combinational 4-bit CLA.
  - Inputs: a[3:0], b[3:0], m, cin.
  - Outputs: s[3:0], c4, c3.
  - Applies the B XOR m inversion internally.
- add_seq16 holds the FSM, operand shift/select, carry register and result staging.

Test Plan:
1. Add, no carry: a=0x1234, b=0x4321, op=0, cin=0 → s=0x5555, cf=0, of=0, zf=0. done_o exactly 5 cycles after start, busy_o high 4 cycles.
2. Full ripple: a=0xFFFF, b=0x0001, op=0, cin=0 → s=0x0000, cf=1, of=0, zf=1. Then a=0xFFFF, b=0x0000, cin=1 → same result.
3. Signed overflow:
   - Add: a=0x7FFF, b=0x0001 → s=0x8000, of=1, cf=0.
   - Sub: a=0x8000, b=0x0001, op=1, cin=0 → s=0x7FFF, of=1, cf=1.
4. Subtract with borrow: a=0x0005, b=0x0007, op=1, cin=0 → s=0xFFFE, cf=0, of=0. Then a=0x0005, b=0x0005, cin=1 → s=0xFFFF, cf=0.
5. Handshake:
   - start_i held high throughout → one operation every 5 cycles, new operands captured only in DONE cycles.
   - start pulse mid-RUN → ignored, result from the first operands only.
6. Abort:
   - flush_i in the 2nd RUN cycle → IDLE next cycle, no done_o, s_o keeps the previous result.
   - rst_n=0 mid-RUN → next cycle all outputs 0, IDLE.
   - New start after release → correct result.
